// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, optional wait states, word array with error flag.
// Optional wait states are compiled in with `define DMEM_WAIT_EN.
module dmem_responder #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wen,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 0..15");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t           state_q, state_d;
   logic             wen_q;
   logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
   logic             err_q, valid_q;
   logic             acc_err;
   logic [AW-1:0]    idx;

   // NOTE: the array has no reset; it starts at zero and only ACCESS stores change it.
   logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

`ifdef DMEM_WAIT_EN
   logic [3:0] cnt_q, cnt_d;
`endif

   assign idx     = addr_q[AW:1];
   assign acc_err = addr_q[0] | (32'(addr_q[WIDTH-1:1]) >= 32'(DEPTH));

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // NOTE: every variable written here gets a default first, so no latches are inferred.
   always_comb begin
      state_d = state_q;
`ifdef DMEM_WAIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
`ifdef DMEM_WAIT_EN
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else begin
                  state_d = S_ACCESS;
               end
`else
               state_d = S_ACCESS;
`endif
            end
         end
         S_WAIT: begin
`ifdef DMEM_WAIT_EN
            if (cnt_q == 4'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
`else
            state_d = S_IDLE;
`endif
         end
         S_ACCESS: state_d = S_RESP;
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req_valid) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state_q == S_ACCESS) begin
            rdata_q <= (!wen_q && !acc_err) ? mem_q[idx] : '0;
            err_q   <= acc_err;
            valid_q <= 1'b1;
         end else if (state_q == S_RESP && rsp_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef DMEM_WAIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (state_q == S_ACCESS && wen_q && !acc_err) mem_q[idx] <= wdata_q;
   end

endmodule
